// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 11-bit frame clocked by the
// device, acknowledge check, open-drain line control through output enables.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 1400,
  parameter int TIMEOUT_CYCLES = 210000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic       PS2_CLK_OE,
  output logic       PS2_DAT_OE,
  input  logic [7:0] TX_DATA,
  input  logic       TX_START,
  output logic       TX_BUSY,
  output logic       TX_DONE,
  output logic       TX_ERR
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_SEND, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic             clk_meta_q, clk_sync_q, clk_prev_q;
  logic             dat_meta_q, dat_sync_q;
  logic             fe_q;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             dat_oe_q, dat_oe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             timeout;

  assign timeout = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      fe_q       <= 1'b0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      bitcnt_q   <= '0;
      inh_cnt_q  <= '0;
      to_cnt_q   <= '0;
      dat_oe_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_meta_q <= PS2_CLK;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= PS2_DAT;
      dat_sync_q <= dat_meta_q;
      fe_q       <= clk_prev_q & ~clk_sync_q;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      bitcnt_q   <= bitcnt_d;
      inh_cnt_q  <= inh_cnt_d;
      to_cnt_q   <= to_cnt_d;
      dat_oe_q   <= dat_oe_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    bitcnt_d  = bitcnt_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = to_cnt_q;
    dat_oe_d  = dat_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        inh_cnt_d = '0;
        to_cnt_d  = '0;
        dat_oe_d  = 1'b0;
        if (TX_START) begin
          shift_d  = TX_DATA;
          parity_d = ~^TX_DATA;
          state_d  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
          dat_oe_d = 1'b1;
          state_d  = S_START;
        end else begin
          inh_cnt_d = inh_cnt_q + INH_W'(1);
        end
      end
      S_START: begin
        to_cnt_d = '0;
        bitcnt_d = '0;
        state_d  = S_SEND;
      end
      S_SEND: begin
        if (timeout) begin
          dat_oe_d = 1'b0;
          err_d    = 1'b1;
          state_d  = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (fe_q) begin
            bitcnt_d = bitcnt_q + 4'd1;
            case (bitcnt_q)
              4'd8:    dat_oe_d = ~parity_q;
              4'd9: begin
                dat_oe_d = 1'b0;
                state_d  = S_ACK;
              end
              default: dat_oe_d = ~shift_q[bitcnt_q[2:0]];
            endcase
          end
        end
      end
      S_ACK: begin
        if (timeout) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (fe_q) begin
            if (dat_sync_q) begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_WAIT_IDLE;
            end
          end
        end
      end
      S_WAIT_IDLE: begin
        // Shares the timeout budget started at clock release.
        if (timeout) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (clk_sync_q && dat_sync_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    PS2_CLK_OE = (state_q == S_INHIBIT) || (state_q == S_START);
    PS2_DAT_OE = dat_oe_q && ((state_q == S_START) || (state_q == S_SEND));
    TX_BUSY    = (state_q != S_IDLE);
    TX_DONE    = done_q;
    TX_ERR     = err_q;
  end

endmodule
